// File: rtl/signed_addsub_seq_if.sv
// Operation request / result bundle for the chunk-serial signed add/subtract unit.
interface signed_addsub_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             op;
  logic             sat_en;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   result_ext;
  logic             ovf;

  modport master (
    output start, op, sat_en, x, y,
    input  busy, done, result, result_ext, ovf
  );

  modport slave (
    input  start, op, sat_en, x, y,
    output busy, done, result, result_ext, ovf
  );
endinterface

// File: rtl/signed_addsub_seq.sv
// Signed add/subtract processed CHUNK bits per clock, LSB slice first, with an
// exact WIDTH+1 result, overflow flag and optional saturation.
module signed_addsub_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst,
  signed_addsub_seq_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_load, w_step, w_last;

  logic [WIDTH-1:0] r_x, r_y, r_sum;
  logic             r_op, r_sat, r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_busy, r_done, r_ovf;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH:0]   r_result_ext;

  logic [CHUNK-1:0] w_xs, w_ys_raw, w_ys;
  logic             w_cin, w_y_msb;
  logic [CHUNK:0]   w_slice;
  logic [WIDTH-1:0] w_sum_full, w_res;
  logic [WIDTH:0]   w_ext;
  logic             w_ovf;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_step = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slice adder; subtraction inverts y per slice and injects carry 1 into slice 0
  always_comb begin
    w_xs     = CHUNK'(r_x >> (int'(r_idx) * CHUNK));
    w_ys_raw = CHUNK'(r_y >> (int'(r_idx) * CHUNK));
    w_ys     = r_op ? ~w_ys_raw : w_ys_raw;
    w_cin    = (r_idx == '0) ? r_op : r_carry;
    w_slice  = {1'b0, w_xs} + {1'b0, w_ys} + {{CHUNK{1'b0}}, w_cin};
    w_sum_full = r_sum;
    w_sum_full[int'(r_idx) * CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
    // Top bit of the sign-extended sum: sign bits plus the carry out of the MSB
    w_y_msb  = r_op ? ~r_y[WIDTH-1] : r_y[WIDTH-1];
    w_ext    = {r_x[WIDTH-1] ^ w_y_msb ^ w_slice[CHUNK], w_sum_full};
    w_ovf    = w_ext[WIDTH] ^ w_ext[WIDTH-1];
    w_res    = w_ext[WIDTH-1:0];
    if (r_sat && w_ovf) begin
      w_res = w_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Operand latch, slice accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_op         <= 1'b0;
      r_sat        <= 1'b0;
      r_sum        <= '0;
      r_carry      <= 1'b0;
      r_idx        <= '0;
      r_result     <= '0;
      r_result_ext <= '0;
      r_ovf        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_load) begin
        r_x     <= bus.x;
        r_y     <= bus.y;
        r_op    <= bus.op;
        r_sat   <= bus.sat_en;
        r_carry <= 1'b0;
        r_idx   <= '0;
      end else if (w_step) begin
        r_sum   <= w_sum_full;
        r_carry <= w_slice[CHUNK];
        r_idx   <= r_idx + 1'b1;
      end
      if (w_last) begin
        r_result     <= w_res;
        r_result_ext <= w_ext;
        r_ovf        <= w_ovf;
      end
      r_busy <= (w_state_nxt == S_BUSY);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.result_ext = r_result_ext;
  assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_signed_addsub_seq.sv
// Directed and back-to-back checks of signed_addsub_seq at WIDTH=8, CHUNK=4.
module tb_signed_addsub_seq;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  signed_addsub_seq_if #(.WIDTH(8)) bus ();

  signed_addsub_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic o, input logic s, input int a, input int b);
    bus.start  = st;
    bus.op     = o;
    bus.sat_en = s;
    bus.x      = 8'(a);
    bus.y      = 8'(b);
  endtask

  task automatic check_out(input string tag, input int ext, input int res, input logic ov);
    check({tag, "_ext"}, $signed(bus.result_ext), ext);
    check({tag, "_res"}, $signed(bus.result), res);
    check({tag, "_ovf"}, bus.ovf, ov);
  endtask

  // start in cycle 0, busy in cycles 1-2, done in cycle 3
  task automatic run_op(input string tag, input logic o, input logic s, input int a, input int b,
                        input int ext, input int res, input logic ov);
    drive(1'b1, o, s, a, b);
    tick();
    check({tag, "_c1_busy"}, bus.busy, 1);
    check({tag, "_c1_done"}, bus.done, 0);
    bus.start = 1'b0;
    tick();
    check({tag, "_c2_busy"}, bus.busy, 1);
    tick();
    check({tag, "_c3_done"}, bus.done, 1);
    check({tag, "_c3_busy"}, bus.busy, 0);
    check_out(tag, ext, res, ov);
  endtask

  function automatic void model(input logic o, input logic s, input int a, input int b,
                                output int ext, output int res, output logic ov);
    ext = o ? a - b : a + b;
    ov  = (ext > 127) || (ext < -128);
    if (s && ov) begin
      res = (ext > 0) ? 127 : -128;
    end else begin
      res = ext & 255;
      if (res > 127) res = res - 256;
    end
  endfunction

  initial begin
    int   a, b, e_ext, e_res;
    logic o, s, e_ov;

    // reset wins over a simultaneous start
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1, 2);
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check_out("rst", 0, 0, 1'b0);
    tick();
    check("rst_prio_busy", bus.busy, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    check("idle_busy", bus.busy, 0);

    run_op("sub_minneg", 1'b1, 1'b0, 5, -128, 133, -123, 1'b1);
    tick();
    check("done_fall", bus.done, 0);
    check_out("hold", 133, -123, 1'b1);

    run_op("sub_sat_neg", 1'b1, 1'b1, -128, 1, -129, -128, 1'b1);
    tick();
    run_op("sub_wrap_neg", 1'b1, 1'b0, -128, 1, -129, 127, 1'b1);
    tick();
    run_op("add_sat_nov", 1'b0, 1'b1, -3, -5, -8, -8, 1'b0);
    tick();
    run_op("add_sat_pos", 1'b0, 1'b1, 127, 127, 254, 127, 1'b1);
    tick();
    run_op("add_wrap_min", 1'b0, 1'b0, -128, -128, -256, 0, 1'b1);
    tick();
    run_op("sub_edge_fit", 1'b1, 1'b1, -1, -128, 127, 127, 1'b0);
    tick();

    // start and operand changes during BUSY are ignored
    drive(1'b1, 1'b0, 1'b0, 10, 20);
    tick();
    drive(1'b1, 1'b1, 1'b1, 100, 100);
    tick();
    check("busy_restart", bus.busy, 1);
    bus.start = 1'b0;
    tick();
    check("busy_ign_done", bus.done, 1);
    check_out("busy_ign", 30, 30, 1'b0);
    tick();

    // reset in cycle 2 aborts without a done pulse
    drive(1'b1, 1'b0, 1'b0, 7, 8);
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check_out("abort", 0, 0, 1'b0);
    rst = 1'b0;
    tick();
    check("abort_nodone", bus.done, 0);
    run_op("after_abort", 1'b0, 1'b0, 7, 8, 15, 15, 1'b0);

    // start held high: one result every three cycles
    for (int k = 0; k < 24; k++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      o = 1'($urandom);
      s = 1'($urandom);
      model(o, s, a, b, e_ext, e_res, e_ov);
      drive(1'b1, o, s, a, b);
      tick();
      check("b2b_busy", bus.busy, 1);
      check("b2b_nodone", bus.done, 0);
      drive(1'b1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      tick();
      drive(1'b1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      tick();
      check("b2b_done", bus.done, 1);
      check_out("b2b", e_ext, e_res, e_ov);
    end
    bus.start = 1'b0;
    tick();
    check("end_idle_busy", bus.busy, 0);
    check("end_idle_done", bus.done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
